uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ byte requesters using round-robin arbitration.
- Accepts a byte from one requester and launches it with a one-cycle uart_tx_en pulse.
- Holds the transmitter busy until uart_tx_done returns, then grants the next requester.
- Sits between the system message sources (status, debug, log) and the uart TX core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; must match the uart TX core.
- CLK_FRE, 50_000_000, system clock frequency in Hz.
- BPS, 115_200, baud rate; used only to derive the timeout.
- TIMEOUT_BITS, 12, watchdog length in bit times. Localparam TIMEOUT_CYCLES = CLK_FRE/BPS*TIMEOUT_BITS.

Ports:
- sys_clk, in, 1, system clock.
- sys_rst, in, 1, reset.
- req_valid, in, NUM_REQ, per-requester byte-pending flag.
- req_data, in, NUM_REQ*DATA_W, packed bytes; requester i uses bits [i*DATA_W +: DATA_W].
- req_ready, out, NUM_REQ, one-hot, one-cycle accept pulse.
- uart_tx_en, out, 1, one-cycle start pulse to the TX core.
- uart_tx_data, out, DATA_W, byte to the TX core.
- uart_tx_done, in, 1, one-cycle end-of-frame pulse from the TX core.
- busy, out, 1, high in every state except IDLE.
- grant_id, out, $clog2(NUM_REQ), index of the current or last granted requester.
- timeout_err, out, 1, one-cycle pulse when the watchdog expires (only with UART_ARB_TIMEOUT_EN).

Interface: one clock sys_clk; reset sys_rst is synchronous and active-high.

Behaviour:
- Reset (sys_rst=1 at a sys_clk edge) forces:
  - state=IDLE, req_ready=0, uart_tx_en=0, uart_tx_data=0, busy=0, grant_id=0, timeout_err=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-frame abandons the frame; no done is awaited afterwards.
- All outputs are registered.
- States: IDLE, START, WAIT.
- IDLE:
  - If req_valid != 0, select the first asserted index scanning last+1, last+2, … modulo NUM_REQ.
  - At the same edge: latch that byte into uart_tx_data, set grant_id, go to START.
  - If req_valid == 0, stay in IDLE.
- START (exactly 1 cycle):
  - uart_tx_en=1 and req_ready[grant_id]=1.
  - Next state is WAIT; last <= grant_id.
- WAIT:
  - uart_tx_data is held stable.
  - On uart_tx_done=1, go to IDLE.
  - Minimum gap between a done and the next uart_tx_en is 2 cycles (IDLE, then START).
- Handshake rules:
  - A requester holds req_valid and its byte stable until it sees req_ready.
  - req_valid may deassert before grant; the arbiter only samples it in IDLE.
- Latency: req_valid high in IDLE at edge N gives uart_tx_en and req_ready at cycle N+1.
- uart_tx_done outside WAIT (including in the START cycle) is ignored.
- Only one req_ready bit is ever high, never two in consecutive cycles.
- Fairness: with all requesters permanently valid, grants cycle 0,1,2,…,NUM_REQ-1,0,… .
- A single active requester is granted back-to-back.
- req_valid with X/Z bits is a bench error; no RTL handling.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without uart_tx_done: pulse timeout_err for 1 cycle and go to IDLE.
  - last keeps the timed-out grant, so that requester loses priority next round.
  - If uart_tx_done arrives on the same cycle the count reaches TIMEOUT_CYCLES, done wins and there is no error.
- Undefined: no counter; timeout_err is tied 0; WAIT waits indefinitely.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, WAIT);
  - DATA_W default;
  - a function computing TIMEOUT_CYCLES from CLK_FRE, BPS and TIMEOUT_BITS.
- Sub-module rr_arbiter: combinational rotate-priority picker.
  - Inputs: req vector, last pointer. Outputs: grant index, any_req.
  - Parameterised by NUM_REQ; reusable elsewhere.
- The FSM, data latch and watchdog stay in uart_tx_arbiter.

Test Plan:
- Reset: hold sys_rst=1 for 4 cycles with req_valid=4'b1111 -> all outputs 0, no uart_tx_en.
- Single grant: req_valid=4'b0100, req_data[23:16]=8'h55 -> one cycle later uart_tx_en=1, req_ready=4'b0100, uart_tx_data=8'h55, grant_id=2; busy stays high until 1 cycle after a modelled uart_tx_done.
- Round-robin: all four valid, data 8'hA0..8'hA3, done returned 20 cycles after each en -> uart_tx_data sequence A0, A1, A2, A3, A0; exactly one req_ready per frame.
- Spurious done: pulse uart_tx_done while in IDLE and in START -> no state change, no extra uart_tx_en.
- Timeout (UART_ARB_TIMEOUT_EN): CLK_FRE=1000, BPS=100, TIMEOUT_BITS=12, never send done -> timeout_err pulses exactly 120 cycles after entering WAIT, then IDLE, and the next grant goes to the next requester.
- Reset mid-WAIT: assert sys_rst during WAIT, then release with requesters 1 and 3 valid -> first grant is requester 1; a stale done after release is ignored.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

  // Byte width of the UART TX core.
  localparam int DATA_W_DEFAULT = 8;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  // Watchdog length in clock cycles: whole cycles per bit times bit count.
  function automatic int calc_timeout_cycles(input int clk_fre, input int bps, input int bits);
    return clk_fre / bps * bits;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational rotating-priority picker: the first asserted request after
// the last granted index (wrapping) wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_o,
  output logic                       any_req_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] idx;

  // Scan from farthest to nearest so the nearest asserted index overwrites the rest.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    grant_o   = '0;
    idx       = '0;
    any_req_o = |req_i;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = IDX_W'((int'(last_i) + off) % NUM_REQ);
      if (req_i[idx]) begin
        grant_o = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Optional watchdog on the end-of-frame handshake: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = DATA_W_DEFAULT,
  parameter int CLK_FRE      = 50_000_000,
  parameter int BPS          = 115_200,
  parameter int TIMEOUT_BITS = 12
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        uart_tx_en,
  output logic [DATA_W-1:0]           uart_tx_data,
  input  logic                        uart_tx_done,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        timeout_err
);

  localparam int IDX_W          = $clog2(NUM_REQ);
  localparam int TIMEOUT_CYCLES = calc_timeout_cycles(CLK_FRE, BPS, TIMEOUT_BITS);

  // Reject parameter sets the design is not meant for.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported NUM_REQ or timeout parameters");
  end

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic                tx_en_q, tx_en_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                busy_q, busy_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    last_q, last_d;

  logic [IDX_W-1:0]    pick;
  logic                any_req;
  logic [DATA_W-1:0]   pick_data;
  logic [NUM_REQ-1:0]  pick_onehot;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i     (req_valid),
    .last_i    (last_q),
    .grant_o   (pick),
    .any_req_o (any_req)
  );

  // Byte and one-hot ready of the requester the picker selected.
  always_comb begin
    pick_data   = '0;
    pick_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IDX_W'(i)) begin
        pick_data      = req_data[i*DATA_W +: DATA_W];
        pick_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state logic: pick in IDLE, pulse in START, wait for done in WAIT.
  always_comb begin
    state_d     = state_q;
    req_ready_d = '0;
    tx_en_d     = 1'b0;
    tx_data_d   = tx_data_q;
    grant_d     = grant_q;
    last_d      = last_q;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          tx_data_d   = pick_data;
          grant_d     = pick;
          req_ready_d = pick_onehot;
          tx_en_d     = 1'b1;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        last_d  = grant_q;
        state_d = ST_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_WAIT: begin
        if (uart_tx_done) begin
          state_d = ST_IDLE;
        end else begin
`ifdef UART_ARB_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge sys_clk) begin
    // NOTE: reset is synchronous, and all state uses non-blocking assignment.
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= '0;
      tx_en_q     <= 1'b0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
      grant_q     <= '0;
      last_q      <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      tx_en_q     <= tx_en_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  // Watchdog counter and its error pulse.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign req_ready    = req_ready_q;
  assign uart_tx_en   = tx_en_q;
  assign uart_tx_data = tx_data_q;
  assign busy         = busy_q;
  assign grant_id     = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed and randomized frames
// against a round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        uart_tx_en;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_done;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  int model_last;
  logic [7:0] bytes [NUM_REQ];

  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .DATA_W       (DATA_W),
    .CLK_FRE      (1000),
    .BPS          (100),
    .TIMEOUT_BITS (12)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .uart_tx_done (uart_tx_done),
    .busy         (busy),
    .grant_id     (grant_id),
    .timeout_err  (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic load_bytes();
    req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
  endtask

  // Reference rule: first valid index after the last grant, wrapping.
  function automatic int rr_pick(input logic [3:0] v, input int last);
    int idx;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (last + k) % NUM_REQ;
      if (v[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic wait_en(input string tag, input int budget, output int n);
    n = 0;
    while (uart_tx_en !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_en"}, 32'(uart_tx_en), 32'd1);
  endtask

  task automatic check_grant(input string tag, input logic [3:0] v, output int n);
    int exp;
    exp = rr_pick(v, model_last);
    wait_en(tag, 8, n);
    check({tag, "_grant"}, 32'(grant_id), 32'(exp));
    check({tag, "_ready"}, 32'(req_ready), 32'(1 << exp));
    check({tag, "_data"},  32'(uart_tx_data), 32'(bytes[exp]));
    check({tag, "_busy"},  32'(busy), 32'd1);
    check({tag, "_terr"},  32'(timeout_err), 32'd0);
    model_last = exp;
  endtask

  // Hold WAIT for wait_cycles, return done, confirm the arbiter goes idle.
  task automatic finish_frame(input string tag, input int wait_cycles);
    int extra;
    extra = 0;
    for (int k = 0; k < wait_cycles; k++) begin
      tick();
      if (uart_tx_en !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b1) extra++;
    end
    uart_tx_done = 1'b1;
    tick();
    uart_tx_done = 1'b0;
    check({tag, "_wait_quiet"}, 32'(extra), 32'd0);
    check({tag, "_idle_busy"},  32'(busy), 32'd0);
  endtask

  initial begin
    #100_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    int exp;
    logic [3:0] v;

    sys_rst      = 1'b1;
    req_valid    = 4'b1111;
    uart_tx_done = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) bytes[i] = 8'(i + 8'h10);
    load_bytes();

    // Reset held four cycles with every requester valid.
    for (int k = 0; k < 4; k++) begin
      tick();
      check("reset_no_en", 32'(uart_tx_en), 32'd0);
    end
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_data",  32'(uart_tx_data), 32'd0);
    check("reset_busy",  32'(busy), 32'd0);
    check("reset_grant", 32'(grant_id), 32'd0);
    check("reset_terr",  32'(timeout_err), 32'd0);
    model_last = NUM_REQ - 1;

    // Single requester 2 with byte 55.
    sys_rst   = 1'b0;
    req_valid = 4'b0000;
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    bytes[2]  = 8'h55;
    load_bytes();
    req_valid = 4'b0100;
    check_grant("single", 4'b0100, n);
    check("single_latency", 32'(n), 32'd1);
    req_valid = 4'b0000;
    finish_frame("single", 5);
    check("single_data_hold", 32'(uart_tx_data), 32'h55);

    // All requesters valid: rotation, done 20 cycles after each en.
    for (int i = 0; i < NUM_REQ; i++) bytes[i] = 8'(8'hA0 + i);
    load_bytes();
    req_valid = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      check("rr_gap", 32'(uart_tx_en), 32'd0);
      check_grant("rr", 4'b1111, n);
      check("rr_next_cycle", 32'(n), 32'd1);
      finish_frame("rr", 19);
    end
    req_valid = 4'b0000;

    // Spurious done in IDLE, then in START.
    uart_tx_done = 1'b1;
    tick();
    uart_tx_done = 1'b0;
    check("spur_idle_en",   32'(uart_tx_en), 32'd0);
    check("spur_idle_busy", 32'(busy), 32'd0);
    bytes[1]  = 8'h3C;
    load_bytes();
    req_valid = 4'b0010;
    check_grant("spur", 4'b0010, n);
    req_valid    = 4'b0000;
    uart_tx_done = 1'b1;
    tick();
    uart_tx_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("spur_start_busy", 32'(busy), 32'd1);
      check("spur_start_en",   32'(uart_tx_en), 32'd0);
      tick();
    end
    finish_frame("spur", 1);

    // Reset in WAIT, release with requesters 1 and 3 and a stale done.
    req_valid = 4'b1000;
    check_grant("pre_rst", 4'b1000, n);
    req_valid = 4'b0000;
    tick();
    tick();
    sys_rst   = 1'b1;
    req_valid = 4'b1010;
    tick();
    tick();
    check("rst_wait_busy",  32'(busy), 32'd0);
    check("rst_wait_grant", 32'(grant_id), 32'd0);
    check("rst_wait_data",  32'(uart_tx_data), 32'd0);
    model_last   = NUM_REQ - 1;
    sys_rst      = 1'b0;
    uart_tx_done = 1'b1;
    check_grant("rst_first", 4'b1010, n);
    tick();
    uart_tx_done = 1'b0;
    check("rst_stale_done", 32'(busy), 32'd1);
    req_valid = 4'b1000;
    finish_frame("rst_first", 3);
    check_grant("rst_next", 4'b1000, n);
    req_valid = 4'b0000;
    finish_frame("rst_next", 2);

    // Randomized frames: random requesters, bytes, junk valid while busy, done delay.
    for (int f = 0; f < 12; f++) begin
      v = 4'($urandom_range(1, 15));
      for (int i = 0; i < NUM_REQ; i++) bytes[i] = 8'($urandom);
      load_bytes();
      req_valid = v;
      check_grant("rand", v, n);
      req_valid = 4'($urandom);
      finish_frame("rand", $urandom_range(1, 20));
    end
    req_valid = 4'b0000;

`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog: no done, error 120 cycles after entering WAIT.
    bytes[0]  = 8'hE7;
    load_bytes();
    req_valid = 4'b0001;
    check_grant("to", 4'b0001, n);
    req_valid = 4'b0011;
    tick();
    exp = 0;
    for (int k = 1; k < 120; k++) begin
      tick();
      if (timeout_err !== 1'b0 || busy !== 1'b1) exp++;
    end
    check("to_early", 32'(exp), 32'd0);
    tick();
    check("to_pulse", 32'(timeout_err), 32'd1);
    check("to_idle",  32'(busy), 32'd0);
    tick();
    check("to_pulse_end", 32'(timeout_err), 32'd0);
    check_grant("to_next", 4'b0011, n);
    req_valid = 4'b0000;
    finish_frame("to_next", 4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
